mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_calc.sv | 50 +++++
 rtl/mul_div_unit.sv | 91 +++++++++
 tb/tb_mul_div_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default latencies
// and op-class helpers.
package md_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMadd  = 3'd4,
    OpMaddu = 3'd5,
    OpMsub  = 3'd6,
    OpMsubu = 3'd7
  } md_op_e;

  localparam int unsigned DefaultMulLat = 5;
  localparam int unsigned DefaultDivLat = 10;

  function automatic logic is_div(input md_op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  // Signed variants sit on the even encodings.
  function automatic logic is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic for the multiply/divide unit: product, accumulate and
// truncating division with the zero-divisor and overflow corner cases.
module md_calc
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_op_e             op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               div_zero_o
);

  logic               sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, b_safe, uq, ur, q, r;

  always_comb begin
    sgn   = is_signed(op_i);
    // Extending to 2*WIDTH and truncating the product is exact for both signednesses.
    a_ext = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    b_ext = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    prod  = a_ext * b_ext;

    a_neg  = sgn & a_i[WIDTH-1];
    b_neg  = sgn & b_i[WIDTH-1];
    a_abs  = a_neg ? -a_i : a_i;
    b_abs  = b_neg ? -b_i : b_i;
    b_safe = (b_abs == '0) ? WIDTH'(1) : b_abs;
    // MIN / -1 falls out naturally: |MIN| stays 2^(W-1), negation wraps back to MIN.
    uq     = a_abs / b_safe;
    ur     = a_abs % b_safe;
    q      = (a_neg ^ b_neg) ? -uq : uq;
    r      = a_neg ? -ur : ur;

    div_zero_o = is_div(op_i) && (b_i == '0);

    res_o = acc_i;
    unique case (op_i)
      OpMult, OpMultu: res_o = prod;
      OpMadd, OpMaddu: res_o = acc_i + prod;
      OpMsub, OpMsubu: res_o = acc_i - prod;
      OpDiv, OpDivu:   res_o = div_zero_o ? acc_i : {r, q};
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, fixed per-class latency
// and a start/busy/done handshake.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = DefaultMulLat,
  parameter int unsigned DIV_LAT = DefaultDivLat
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             hi_sel,
  output logic [WIDTH-1:0] md_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  md_op_e             op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, res;
  logic [CntW-1:0]    cnt_q, lat_sel;
  logic               busy_q, done_q, div_zero_q, calc_dz;

  md_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .acc_i     (acc_q),
    .res_o     (res),
    .div_zero_o(calc_dz)
  );

  assign lat_sel = is_div(md_op_e'(op)) ? CntW'(DIV_LAT) : CntW'(MUL_LAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OpMult;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        if (cnt_q == CntW'(1)) begin
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          div_zero_q <= calc_dz;
          hi_q       <= res[2*WIDTH-1:WIDTH];
          lo_q       <= res[WIDTH-1:0];
          cnt_q      <= '0;
        end else begin
          cnt_q <= cnt_q - CntW'(1);
        end
      end else if (start) begin
        op_q   <= md_op_e'(op);
        a_q    <= src_a;
        b_q    <= src_b;
        acc_q  <= {hi_q, lo_q};
        cnt_q  <= lat_sel;
        busy_q <= 1'b1;
      end else begin
        if (mthi) hi_q <= src_a;
        if (mtlo) lo_q <= src_a;
      end
    end
  end

  assign md_out   = hi_sel ? hi_q : lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus hand-written busy/reset sequences.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, mthi, mtlo, hi_sel;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b, md_out;
  logic         busy, done, div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .WIDTH  (32),
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .hi_sel  (hi_sel),
    .md_out  (md_out),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] pre_hi, pre_lo, a, b, hi, lo;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hl(output logic [W-1:0] hi, output logic [W-1:0] lo);
    hi_sel = 1'b1;
    #1 hi = md_out;
    hi_sel = 1'b0;
    #1 lo = md_out;
  endtask

  task automatic preset(input logic [W-1:0] hi, input logic [W-1:0] lo);
    src_a = hi;
    mthi  = 1'b1;
    tick();
    mthi  = 1'b0;
    src_a = lo;
    mtlo  = 1'b1;
    tick();
    mtlo  = 1'b0;
  endtask

  // Issue one op; count busy cycles, then sample done/div_zero and the following cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cycles, output logic done_at, output logic done_after,
                        output logic dz);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      tick();
    end
    done_at = done;
    dz      = div_zero;
    tick();
    done_after = done;
  endtask

  initial begin
    logic [W-1:0] hi, lo;
    int           cyc;
    logic         d0, d1, dz;

    vecs[0]  = '{3'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5};
    vecs[1]  = '{3'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 5};
    vecs[2]  = '{3'd2, 32'h0, 32'h0, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10};
    vecs[3]  = '{3'd2, 32'h5, 32'h5, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 10};
    vecs[4]  = '{3'd3, 32'h12345678, 32'h12345678, 32'h7, 32'h0, 32'h12345678, 32'h12345678,
                 1'b1, 10};
    vecs[5]  = '{3'd4, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h1, 32'h0, 1'b0, 5};
    vecs[6]  = '{3'd7, 32'h1, 32'h0, 32'h1, 32'h2, 32'h0, 32'hFFFFFFFE, 1'b0, 5};
    vecs[7]  = '{3'd3, 32'h0, 32'h0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 10};
    vecs[8]  = '{3'd2, 32'h0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 10};
    vecs[9]  = '{3'd6, 32'h0, 32'h10, 32'd3, 32'hFFFFFFFE, 32'h0, 32'h16, 1'b0, 5};
    vecs[10] = '{3'd5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 5};
    vecs[11] = '{3'd2, 32'h0, 32'h0, 32'hFFFFFFF8, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 10};

    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    src_a  = '0;
    src_b  = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    hi_sel = 1'b0;
    repeat (3) tick();
    read_hl(hi, lo);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dz", div_zero, 0);
    reset = 1'b1;
    tick();

    // mthi and mtlo together write the same data.
    src_a = 32'h5A5A;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    read_hl(hi, lo);
    check("mt_both_hi", hi, 32'h5A5A);
    check("mt_both_lo", lo, 32'h5A5A);

    for (int i = 0; i < 12; i++) begin
      preset(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, d0, d1, dz);
      read_hl(hi, lo);
      check($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].lat);
      check($sformatf("v%0d_done", i), d0, 1);
      check($sformatf("v%0d_done_pulse", i), d1, 0);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      if (vecs[i].op inside {3'd2, 3'd3}) check($sformatf("v%0d_dz", i), dz, vecs[i].dz);
    end

    // div_zero holds until the next done.
    run_op(3'd3, 32'd7, 32'd0, cyc, d0, d1, dz);
    repeat (3) tick();
    check("dz_hold", div_zero, 1);
    run_op(3'd3, 32'd7, 32'd1, cyc, d0, d1, dz);
    check("dz_clear", dz, 0);

    // start/mthi/mtlo during busy are ignored.
    preset(32'h0, 32'h0);
    hi_sel = 1'b1;
    op     = 3'd0;
    src_a  = 32'hFFFFFFFF;
    src_b  = 32'h2;
    start  = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == 3) check("busy_hi_untouched", md_out, 0);
      if (cyc == 2) begin
        start = 1'b1;
        op    = 3'd2;
        src_a = 32'hAAAA;
        src_b = 32'h0;
        mthi  = 1'b1;
        mtlo  = 1'b1;
      end else begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      tick();
    end
    check("ignore_busy_cycles", cyc, 5);
    check("ignore_done", done, 1);
    read_hl(hi, lo);
    check("ignore_hi", hi, 32'hFFFFFFFF);
    check("ignore_lo", lo, 32'hFFFFFFFE);
    tick();
    check("ignore_no_second_op", busy, 0);

    // mthi/mtlo ignored when start is accepted in the same cycle.
    preset(32'h0, 32'h0);
    op    = 3'd4;
    src_a = 32'd5;
    src_b = 32'd1;
    start = 1'b1;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    read_hl(hi, lo);
    check("accept_mthi_ignored", hi, 0);
    check("accept_mtlo_ignored", lo, 0);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      tick();
    end
    read_hl(hi, lo);
    check("accept_madd_hi", hi, 0);
    check("accept_madd_lo", lo, 5);

    // Reset in busy cycle 4 of a divide.
    preset(32'h11, 32'h22);
    op    = 3'd2;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("rst_mid_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    read_hl(hi, lo);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    d0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      d0 |= done;
    end
    check("rst_mid_no_done", d0, 0);
    reset = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, cyc, d0, d1, dz);
    read_hl(hi, lo);
    check("post_rst_cycles", cyc, 5);
    check("post_rst_done", d0, 1);
    check("post_rst_hi", hi, 0);
    check("post_rst_lo", lo, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
